// File: rtl/mem_port_arbiter_pkg.sv
// Types and the arbitration rule shared by the unified memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

  // DM wins unless a waiting fetch has already lost the maximum number of
  // rounds; a fetch takes any slot DM does not claim.
  function automatic owner_e pick_winner(input logic if_req,
                                         input logic dm_req,
                                         input logic starve_sat);
    if (dm_req && !(if_req && starve_sat)) return OWN_DM;
    else if (if_req)                       return OWN_IF;
    else                                   return OWN_NONE;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response bus between the datapath, the arbiter and the memory macro.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, if_flush,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // Datapath plus memory side.
  modport master (
    output if_req, if_addr, if_flush,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: one transaction in flight, DM priority with a
// starvation guard that forces a fetch grant after STARVE_MAX DM wins.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus,
  output logic               busy,
  output logic [1:0]         debug_owner
);

  localparam int LW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
  localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [LW-1:0] LAT_LOAD = LW'(MEM_LAT);
  localparam logic [SW-1:0] STARVE_SAT = SW'(STARVE_MAX);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ISSUE = ISSUE;
  localparam logic [1:0] S_WAIT  = WAIT;

  logic [1:0]        state_q;
  owner_e            owner_q;
  logic [SW-1:0]     starve_q;
  logic [LW-1:0]     lat_q;
  logic              flushed_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  owner_e winner;
  logic   starve_sat;
  logic   flush_hit;
  logic   issue;
  logic   done;

  assign starve_sat = (starve_q == STARVE_SAT);
  assign winner     = pick_winner(bus.if_req, bus.dm_req, starve_sat);
  assign flush_hit  = bus.if_flush && (owner_q == OWN_IF);

  // Control FSM, latency countdown, starvation counter and flush tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_NONE;
      starve_q  <= '0;
      lat_q     <= '0;
      flushed_q <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (winner != OWN_NONE) begin
            state_q   <= S_ISSUE;
            owner_q   <= winner;
            flushed_q <= 1'b0;
            we_q      <= (winner == OWN_DM) && bus.dm_we;
            if (winner == OWN_IF)
              starve_q <= '0;
            else if (bus.if_req && !starve_sat)
              starve_q <= starve_q + 1'b1;
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
          lat_q   <= LAT_LOAD;
          if (flush_hit) flushed_q <= 1'b1;
        end
        S_WAIT: begin
          if (flush_hit) flushed_q <= 1'b1;
          if (lat_q == LW'(1)) begin
            state_q <= S_IDLE;
            owner_q <= OWN_NONE;
            lat_q   <= '0;
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Capture the winner's address and store data at arbitration time.
  always_ff @(posedge clk) begin
    if ((state_q == S_IDLE) && (winner != OWN_NONE)) begin
      addr_q  <= (winner == OWN_DM) ? bus.dm_addr : bus.if_addr;
      wdata_q <= (winner == OWN_DM) ? bus.dm_wdata : '0;
    end
  end

  assign issue = (state_q == S_ISSUE);
  assign done  = (state_q == S_WAIT) && (lat_q == LW'(1));

  assign bus.if_gnt    = issue && (owner_q == OWN_IF);
  assign bus.dm_gnt    = issue && (owner_q == OWN_DM);
  assign bus.mem_en    = issue;
  assign bus.mem_we    = issue && we_q;
  assign bus.mem_addr  = issue ? addr_q : '0;
  assign bus.mem_wdata = issue ? wdata_q : '0;

  // A flush seen at any point of the fetch, including the data cycle itself,
  // hides the response; the memory read still runs to completion.
  assign bus.if_rvalid = done && (owner_q == OWN_IF) && !flushed_q && !bus.if_flush;
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
  assign bus.dm_rvalid = done && (owner_q == OWN_DM);
  assign bus.dm_rdata  = (bus.dm_rvalid && !we_q) ? bus.mem_rdata : '0;

  assign busy        = (state_q != S_IDLE);
  assign debug_owner = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3), a
// cycle-numbered transaction model compared every cycle, plus directed checks.
module tb_mem_port_arbiter;

  localparam int SMAX = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       if_req, if_flush, dm_req, dm_we;
  logic [1:0][15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  wire  [1:0]       if_gnt_o, if_rvalid_o, dm_gnt_o, dm_rvalid_o, mem_en_o, mem_we_o, busy_o;
  wire  [1:0][15:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
  wire  [1:0][1:0]  owner_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  for (genvar d = 0; d < 2; d++) begin : g_dut
    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();
    assign bus.if_req    = if_req[d];
    assign bus.if_addr   = if_addr[d];
    assign bus.if_flush  = if_flush[d];
    assign bus.dm_req    = dm_req[d];
    assign bus.dm_we     = dm_we[d];
    assign bus.dm_addr   = dm_addr[d];
    assign bus.dm_wdata  = dm_wdata[d];
    assign bus.mem_rdata = mem_rdata[d];
    assign if_gnt_o[d]    = bus.if_gnt;
    assign if_rvalid_o[d] = bus.if_rvalid;
    assign if_rdata_o[d]  = bus.if_rdata;
    assign dm_gnt_o[d]    = bus.dm_gnt;
    assign dm_rvalid_o[d] = bus.dm_rvalid;
    assign dm_rdata_o[d]  = bus.dm_rdata;
    assign mem_en_o[d]    = bus.mem_en;
    assign mem_we_o[d]    = bus.mem_we;
    assign mem_addr_o[d]  = bus.mem_addr;
    assign mem_wdata_o[d] = bus.mem_wdata;

    mem_port_arbiter #(
      .ADDR_W(16), .DATA_W(16), .MEM_LAT((d == 0) ? 1 : 3), .STARVE_MAX(SMAX)
    ) u_dut (
      .clk(clk), .reset(reset), .bus(bus), .busy(busy_o[d]), .debug_owner(owner_o[d])
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transaction model: a grant taken at the edge opening cycle g owns the
  // port for cycles g..g+LAT, answers in cycle g+LAT, and the next sample
  // edge is the one opening cycle g+LAT+2.
  int          m_g      [2] = '{-1, -1};
  int          m_owner  [2] = '{0, 0};
  int          m_starve [2] = '{0, 0};
  int          m_free   [2] = '{0, 0};
  logic        m_we     [2] = '{1'b0, 1'b0};
  logic        m_fl     [2] = '{1'b0, 1'b0};
  logic [15:0] m_addr   [2] = '{16'h0, 16'h0};
  logic [15:0] m_wdata  [2] = '{16'h0, 16'h0};

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int w;
      w = 0;
      if (!reset) begin
        m_g[d] = -1; m_starve[d] = 0; m_free[d] = 0; m_fl[d] = 1'b0;
      end else begin
        if (m_g[d] >= 0 && m_owner[d] == 1 && if_flush[d] &&
            cyc >= m_g[d] && cyc <= m_g[d] + lat_of(d))
          m_fl[d] = 1'b1;
        if (cyc + 1 >= m_free[d]) begin
          if (dm_req[d] && !(if_req[d] && m_starve[d] == SMAX)) w = 2;
          else if (if_req[d]) w = 1;
          if (w == 2 && if_req[d] && m_starve[d] < SMAX) m_starve[d]++;
          if (w == 1) m_starve[d] = 0;
          if (w != 0) begin
            m_g[d] = cyc + 1;
            m_free[d] = cyc + 1 + lat_of(d) + 2;
            m_owner[d] = w;
            m_we[d] = (w == 2) && dm_we[d];
            m_addr[d] = (w == 2) ? dm_addr[d] : if_addr[d];
            m_wdata[d] = dm_wdata[d];
            m_fl[d] = 1'b0;
          end
        end
      end
    end
    cyc++;
  end

  logic [1:0] p_ir = 2'b00, p_ig = 2'b00, p_dr = 2'b00, p_dg = 2'b00;

  // Compare every cycle, mid-cycle, against the model.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic act, en, rv, irv, drv;
      logic [8:0] ac, ec;
      ac = {busy_o[d], owner_o[d], if_gnt_o[d], dm_gnt_o[d], mem_en_o[d], mem_we_o[d],
            if_rvalid_o[d], dm_rvalid_o[d]};
      if (!reset) begin
        chk($sformatf("d%0d_reset_ctrl", d), 64'(ac), 64'h0);
        chk($sformatf("d%0d_reset_data", d),
            {if_rdata_o[d], dm_rdata_o[d], mem_addr_o[d], mem_wdata_o[d]}, 64'h0);
        p_ir[d] = 1'b0; p_dr[d] = 1'b0;
      end else begin
        act = (m_g[d] >= 0) && (cyc >= m_g[d]) && (cyc <= m_g[d] + lat_of(d));
        en  = act && (cyc == m_g[d]);
        rv  = act && (cyc == m_g[d] + lat_of(d));
        irv = rv && (m_owner[d] == 1) && !m_fl[d] && !if_flush[d];
        drv = rv && (m_owner[d] == 2);
        ec = {act, (act ? m_owner[d][1:0] : 2'b00), en && (m_owner[d] == 1),
              en && (m_owner[d] == 2), en, en && m_we[d], irv, drv};
        chk($sformatf("d%0d_ctrl", d), 64'(ac), 64'(ec));
        chk($sformatf("d%0d_if_rdata", d), 64'(if_rdata_o[d]), 64'(irv ? mem_rdata[d] : 16'h0));
        chk($sformatf("d%0d_dm_rdata", d), 64'(dm_rdata_o[d]),
            64'((drv && !m_we[d]) ? mem_rdata[d] : 16'h0));
        if (en) chk($sformatf("d%0d_mem_addr", d), 64'(mem_addr_o[d]), 64'(m_addr[d]));
        if (en && m_we[d]) chk($sformatf("d%0d_mem_wdata", d), 64'(mem_wdata_o[d]), 64'(m_wdata[d]));
        chk($sformatf("d%0d_req_drop_protocol", d),
            64'((p_ir[d] && !p_ig[d] && !if_req[d]) || (p_dr[d] && !p_dg[d] && !dm_req[d])), 64'h0);
        p_ir[d] = if_req[d]; p_ig[d] = if_gnt_o[d];
        p_dr[d] = dm_req[d]; p_dg[d] = dm_gnt_o[d];
      end
    end
  end

  // Called just after a rising edge; returns at mid-cycle of the grant cycle.
  task automatic wait_gnt(input int d, input bit dm, output int gc);
    gc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dm ? dm_gnt_o[d] : if_gnt_o[d]) begin
        gc = cyc;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; failures++;
    $display("FAIL wait_gnt: dut %0d got no grant, want one within 20 cycles", d);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    int g1, g2, r1, ng;
    string order;
    bit drop_if, drop_dm;
    if_req = '0; if_flush = '0; dm_req = '0; dm_we = '0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    mem_rdata[0] = 16'h1234; mem_rdata[1] = 16'hCAFE;

    // 1: fetch straight out of reset
    if_req[0] = 1'b1; if_addr[0] = 16'h0004;
    @(negedge clk);
    chk("reset_busy", 64'(busy_o[0]), 64'h0);
    chk("reset_if_gnt", 64'(if_gnt_o[0]), 64'h0);
    chk("reset_owner", 64'(owner_o[0]), 64'h0);
    @(posedge clk); #1 reset = 1'b1;
    next_cycle(); @(negedge clk);
    chk("t1_if_gnt", 64'(if_gnt_o[0]), 64'h1);
    chk("t1_mem_addr", 64'(mem_addr_o[0]), 64'h0004);
    chk("t1_busy_c1", 64'(busy_o[0]), 64'h1);
    chk("t1_owner", 64'(owner_o[0]), 64'h1);
    next_cycle(); if_req[0] = 1'b0; @(negedge clk);
    chk("t1_if_rvalid", 64'(if_rvalid_o[0]), 64'h1);
    chk("t1_if_rdata", 64'(if_rdata_o[0]), 64'h1234);
    chk("t1_busy_c2", 64'(busy_o[0]), 64'h1);
    next_cycle(); @(negedge clk);
    chk("t1_busy_c3", 64'(busy_o[0]), 64'h0);
    next_cycle();

    // 2: both requesters held, starvation guard
    mem_rdata[0] = 16'hA5A5;
    if_addr[0] = 16'h0100; dm_addr[0] = 16'h0200; dm_we[0] = 1'b0;
    if_req[0] = 1'b1; dm_req[0] = 1'b1;
    order = ""; ng = 0; drop_if = 1'b0; drop_dm = 1'b0;
    for (int i = 0; i < 80 && (if_req[0] || dm_req[0]); i++) begin
      @(negedge clk);
      if (if_gnt_o[0]) begin
        if (ng < 8) order = {order, "I"};
        ng++;
        if (ng >= 8) drop_if = 1'b1;
      end
      if (dm_gnt_o[0]) begin
        if (ng < 8) order = {order, "D"};
        ng++;
        if (ng >= 8) drop_dm = 1'b1;
      end
      next_cycle();
      if (drop_if) if_req[0] = 1'b0;
      if (drop_dm) dm_req[0] = 1'b0;
    end
    checks++;
    if (order != "DDDIDDDI") begin
      failures++;
      $display("FAIL t2_grant_order: got %s, want DDDIDDDI", order);
    end
    chk("t2_reqs_released", 64'({if_req[0], dm_req[0]}), 64'h0);

    // 3: store
    dm_req[0] = 1'b1; dm_we[0] = 1'b1; dm_addr[0] = 16'h0010; dm_wdata[0] = 16'hBEEF;
    wait_gnt(0, 1'b1, g1);
    chk("t3_mem_en", 64'(mem_en_o[0]), 64'h1);
    chk("t3_mem_we", 64'(mem_we_o[0]), 64'h1);
    chk("t3_mem_addr", 64'(mem_addr_o[0]), 64'h0010);
    chk("t3_mem_wdata", 64'(mem_wdata_o[0]), 64'hBEEF);
    next_cycle(); dm_req[0] = 1'b0; dm_we[0] = 1'b0; @(negedge clk);
    chk("t3_dm_rvalid", 64'(dm_rvalid_o[0]), 64'h1);
    chk("t3_dm_rdata", 64'(dm_rdata_o[0]), 64'h0);
    next_cycle();

    // 4: flush in WAIT, then flush in IDLE has no effect
    if_req[0] = 1'b1; if_addr[0] = 16'h0020;
    wait_gnt(0, 1'b0, g1);
    next_cycle(); if_req[0] = 1'b0; if_flush[0] = 1'b1; @(negedge clk);
    chk("t4_flushed_rvalid", 64'(if_rvalid_o[0]), 64'h0);
    chk("t4_flushed_rdata", 64'(if_rdata_o[0]), 64'h0);
    chk("t4_busy_wait", 64'(busy_o[0]), 64'h1);
    next_cycle(); if_req[0] = 1'b1; if_addr[0] = 16'h0022; @(negedge clk);
    chk("t4_idle_busy", 64'(busy_o[0]), 64'h0);
    next_cycle(); if_flush[0] = 1'b0; @(negedge clk);
    chk("t4_regrant", 64'(if_gnt_o[0]), 64'h1);
    chk("t4_regrant_addr", 64'(mem_addr_o[0]), 64'h0022);
    next_cycle(); if_req[0] = 1'b0; @(negedge clk);
    chk("t4_rvalid_after", 64'(if_rvalid_o[0]), 64'h1);
    chk("t4_rdata_after", 64'(if_rdata_o[0]), 64'hA5A5);
    next_cycle();

    // 5: reset during WAIT of a load
    mem_rdata[0] = 16'h5A5A;
    dm_req[0] = 1'b1; dm_addr[0] = 16'h0030;
    wait_gnt(0, 1'b1, g1);
    next_cycle(); dm_req[0] = 1'b0;
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t5_rst_busy", 64'(busy_o[0]), 64'h0);
    chk("t5_rst_dm_rvalid", 64'(dm_rvalid_o[0]), 64'h0);
    chk("t5_rst_dm_rdata", 64'(dm_rdata_o[0]), 64'h0);
    chk("t5_rst_owner", 64'(owner_o[0]), 64'h0);
    next_cycle(); reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_no_stale_rvalid", 64'({dm_rvalid_o[0], busy_o[0]}), 64'h0);
      next_cycle();
    end
    dm_req[0] = 1'b1; dm_addr[0] = 16'h0032;
    wait_gnt(0, 1'b1, g1);
    chk("t5_fresh_addr", 64'(mem_addr_o[0]), 64'h0032);
    next_cycle(); dm_req[0] = 1'b0; @(negedge clk);
    chk("t5_fresh_rvalid", 64'(dm_rvalid_o[0]), 64'h1);
    chk("t5_fresh_rdata", 64'(dm_rdata_o[0]), 64'h5A5A);
    next_cycle();

    // 6: MEM_LAT = 3 instance, fetch request held across two grants
    if_req[1] = 1'b1; if_addr[1] = 16'h0040;
    wait_gnt(1, 1'b0, g1);
    chk("t6_mem_addr", 64'(mem_addr_o[1]), 64'h0040);
    next_cycle();
    r1 = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if_rvalid_o[1]) begin
        r1 = cyc;
        chk("t6_if_rdata", 64'(if_rdata_o[1]), 64'hCAFE);
        break;
      end
      next_cycle();
    end
    next_cycle();
    wait_gnt(1, 1'b0, g2);
    next_cycle(); if_req[1] = 1'b0;
    chk("t6_rvalid_offset", 64'(r1 - g1), 64'd3);
    chk("t6_regrant_offset", 64'(g2 - g1), 64'd5);
    repeat (6) next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000, want finished");
    $fatal(1, "watchdog");
  end

endmodule
